// File: rtl/ram512_copy_dma.sv
// ram512_copy_dma: block-copy initiator for a 512x16 RAM, 1 word/clock via a read->write pipeline.
// Optional RAM_COPY_CHECKSUM_EN adds a running checksum of all written words.
module ram512_copy_dma #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_d_out,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_d_in
`ifdef RAM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;
    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   len_sat;
    assign len_sat     = (len > MAX_LEN) ? MAX_LEN : len;
    // read address holds after the last read, so it doubles as the pointer
    assign mem_rd_addr = rd_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wr_addr <= '0;
            mem_d_in    <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
`ifdef RAM_COPY_CHECKSUM_EN
            if (mem_wr) checksum <= checksum + mem_d_in;
`endif
            case (state)
                IDLE: if (start) begin
`ifdef RAM_COPY_CHECKSUM_EN
                    checksum <= '0;
`endif
                    if (len_sat == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rd_ptr    <= src_addr;
                        wr_ptr    <= dst_addr;
                        remaining <= len_sat;
                    end
                end
                RUN: begin
                    mem_d_in    <= mem_d_out;
                    mem_wr      <= 1'b1;
                    mem_wr_addr <= wr_ptr;
                    wr_ptr      <= wr_ptr + ADDR_W'(1);
                    remaining   <= remaining - (ADDR_W+1)'(1);
                    if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
                    else rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                DRAIN: begin
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram512_copy_dma.sv
// tb_ram512_copy_dma: directed self-checking bench for ram512_copy_dma against a behavioural 512x16 RAM.
module tb_ram512_copy_dma;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  src_addr = '0;
    logic [8:0]  dst_addr = '0;
    logic [9:0]  len = '0;
    logic        busy, done, mem_wr;
    logic [8:0]  mem_rd_addr, mem_wr_addr;
    logic [15:0] mem_d_out, mem_d_in;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [15:0] ram [0:511];
    int n_checks = 0;
    int n_fail = 0;
    int rd_log [16];
    int wr_log [16];
    int bcyc, dcyc, nwr, dcount;

    ram512_copy_dma dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .mem_rd_addr(mem_rd_addr), .mem_d_out(mem_d_out),
        .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_d_in(mem_d_in)
`ifdef RAM_COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    assign mem_d_out = ram[mem_rd_addr];
    always @(posedge clk) if (mem_wr) ram[mem_wr_addr] <= mem_d_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // rep >= 0 re-pulses start with different arguments during that cycle
    task automatic run_copy(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l, input int rep);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bcyc = 0; dcyc = -1; nwr = 0; dcount = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (c == rep) begin
                start = 1'b1; src_addr = 9'h0AA; dst_addr = 9'h0BB; len = 10'd3;
            end
            if (c == rep + 1) start = 1'b0;
            if (busy) bcyc++;
            if (busy && c < 16) rd_log[c] = int'(mem_rd_addr);
            if (mem_wr) begin
                if (nwr < 16) wr_log[nwr] = int'(mem_wr_addr);
                nwr++;
            end
            if (done) begin
                dcount++;
                if (dcyc < 0) dcyc = c;
            end
            if (dcyc >= 0 && c > dcyc + 6) break;
        end
        check("done_seen", dcyc >= 0, 1);
    endtask

    initial begin
        int dseen;
        int exp_rd [4];
        int exp_wr [4];
        for (int i = 0; i < 512; i++) ram[i] = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_d_in", mem_d_in, 0);
`ifdef RAM_COPY_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        @(negedge clk) reset = 1'b0;

        // basic copy
        ram[9'h010] = 16'h1111; ram[9'h011] = 16'h2222; ram[9'h012] = 16'h3333; ram[9'h013] = 16'h4444;
        run_copy(9'h010, 9'h100, 10'd4, -1);
        check("t1_w0", ram[9'h100], 16'h1111);
        check("t1_w1", ram[9'h101], 16'h2222);
        check("t1_w2", ram[9'h102], 16'h3333);
        check("t1_w3", ram[9'h103], 16'h4444);
        check("t1_busy_cycles", bcyc, 5);
        check("t1_done_cycle", dcyc, 5);
        check("t1_writes", nwr, 4);
        check("t1_done_count", dcount, 1);
`ifdef RAM_COPY_CHECKSUM_EN
        check("t1_checksum", checksum, 16'hAAAA);
`endif

        // zero length
        run_copy(9'h030, 9'h040, 10'd0, -1);
        check("t2_writes", nwr, 0);
        check("t2_busy_cycles", bcyc, 0);
        check("t2_done_cycle", dcyc, 0);
        check("t2_done_count", dcount, 1);

        // address wrap
        exp_rd = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        exp_wr = '{9'h0FE, 9'h0FF, 9'h100, 9'h101};
        run_copy(9'h1FE, 9'h0FE, 10'd4, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rd%0d", i), rd_log[i], exp_rd[i]);
            check($sformatf("t3_wr%0d", i), wr_log[i], exp_wr[i]);
        end

        // overlapping shift-up by one
        for (int i = 0; i < 8; i++) ram[9'h020 + i] = 16'(9'h020 + i);
        run_copy(9'h020, 9'h021, 10'd7, -1);
        check("t4_head", ram[9'h020], 16'h0020);
        for (int i = 0; i < 7; i++) check($sformatf("t4_w%0d", i), ram[9'h021 + i], 16'(9'h020 + i));

        // start re-pulsed while running
        for (int i = 0; i < 6; i++) ram[9'h050 + i] = 16'(16'h00A0 + i);
        run_copy(9'h050, 9'h060, 10'd6, 1);
        check("t5_done_count", dcount, 1);
        check("t5_busy_cycles", bcyc, 7);
        check("t5_writes", nwr, 6);
        check("t5_last", ram[9'h065], 16'h00A5);
        check("t5_ignored_dst", ram[9'h0BB], 16'h0000);

        // reset mid-copy
        for (int i = 0; i < 8; i++) begin
            ram[9'h070 + i] = 16'(16'h0700 + i);
            ram[9'h180 + i] = 16'hFFFF;
        end
        @(negedge clk);
        src_addr = 9'h070; dst_addr = 9'h180; len = 10'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("t6_wr_before", mem_wr, 1);
        reset = 1'b1;
        #1 check("t6_wr_async", mem_wr, 0);
        check("t6_busy_async", busy, 0);
        dseen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("t6_no_done", dseen, 0);
        check("t6_w0", ram[9'h180], 16'h0700);
        check("t6_w1", ram[9'h181], 16'h0701);
        check("t6_w2_untouched", ram[9'h182], 16'hFFFF);
        check("t6_w7_untouched", ram[9'h187], 16'hFFFF);
        reset = 1'b0;
        run_copy(9'h070, 9'h180, 10'd8, -1);
        check("t6_redo_w2", ram[9'h182], 16'h0702);
        check("t6_redo_w7", ram[9'h187], 16'h0707);
        check("t6_redo_done_count", dcount, 1);

        // oversized length saturates
        run_copy(9'h000, 9'h000, 10'd600, -1);
        check("t7_busy_cycles", bcyc, 513);
        check("t7_writes", nwr, 512);
        check("t7_done_cycle", dcyc, 513);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
